esp8266_frame_encoder: RTL

- Parametrised multi-channel telemetry frame encoder for the ESP8266 link.
- Periodically, or on demand, snapshots NCH tagged BCD readings and serialises one ASCII line per enabled channel, e.g. m("T","12.5")\r\n.
- Sits between the sensor/BCD conversion logic and the UART TX byte interface; fully synchronous to Clk.
- Uses a valid/ready byte handshake instead of a derived strobe clock.

---
 rtl/esp8266_frame_encoder_if.sv | 8 +
 rtl/esp8266_frame_encoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/esp8266_frame_encoder_if.sv
// esp8266_frame_encoder_if: valid/ready byte stream toward the UART transmitter
interface esp8266_frame_encoder_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/esp8266_frame_encoder.sv
// esp8266_frame_encoder: snapshots tagged BCD channels and streams one m("tag","value")\r\n line per enabled channel
module esp8266_frame_encoder #(
  parameter int NCH = 4,
  parameter int INT_DIGITS = 2,
  parameter int FRAC_DIGITS = 1,
  parameter int PERIOD = 2000000,
  parameter int CNTW = 24
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic [8*NCH-1:0] ch_tag,
  input  logic [4*(INT_DIGITS+FRAC_DIGITS)*NCH-1:0] ch_bcd,
  input  logic [NCH-1:0] ch_en,
  input  logic start,
  esp8266_frame_encoder_if.master tx,
  output logic busy,
  output logic frame_done,
  output logic [15:0] frame_cnt
);
  localparam int D = INT_DIGITS + FRAC_DIGITS;
  localparam int DOT = FRAC_DIGITS > 0 ? 1 : 0;
  localparam int L = 11 + D + DOT;
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int IW = $clog2(L);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic [8*NCH-1:0] tag_q, tag_d;
  logic [4*D*NCH-1:0] bcd_q, bcd_d;
  logic [NCH-1:0] en_q, en_d;
  logic [CHW-1:0] ch_q, ch_d, nxt_ch;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic wrap, req, nxt_ok;

  function automatic logic [7:0] digit(logic [3:0] n);
    return n > 4'd9 ? 8'h3F : {4'h3, n};
  endfunction

  // Lowest enabled channel at or above 'from'; MSB of the result flags that one exists.
  function automatic logic [CHW:0] next_en(logic [NCH-1:0] m, int from);
    logic [CHW:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (i >= from && m[i]) res = {1'b1, CHW'(i)};
    return res;
  endfunction

  // Byte 'idx' of the line for snapshot channel 'ch'; digits are taken MS nibble first.
  function automatic logic [7:0] line_byte(logic [CHW-1:0] ch, logic [IW-1:0] idx);
    int i, p, q, b;
    i = int'(idx);
    p = i - 7;
    q = p - INT_DIGITS - DOT;
    b = D * int'(ch) + D - 1;
    if (i < 7) return i == 0 ? "m" : i == 1 ? "(" : i == 3 ? tag_q[8*int'(ch) +: 8] : i == 5 ? "," : 8'h22;
    if (p < INT_DIGITS) return digit(bcd_q[4*(b-p) +: 4]);
    if (q < 0) return ".";
    if (q < FRAC_DIGITS) return digit(bcd_q[4*(b-INT_DIGITS-q) +: 4]);
    return q == FRAC_DIGITS ? 8'h22 : q == FRAC_DIGITS + 1 ? ")" : q == FRAC_DIGITS + 2 ? 8'h0D : 8'h0A;
  endfunction

  // Next-state: period counter, request coalescing, frame sequencing and registered outputs.
  always_comb begin
    wrap = cnt_q == CNTW'(PERIOD - 1);
    req = wrap | start;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    {nxt_ok, nxt_ch} = next_en(en_q, int'(ch_q) + 1);
    state_d = state_q;
    pend_d = pend_q | req;
    tag_d = tag_q;
    bcd_d = bcd_q;
    en_d = en_q;
    ch_d = ch_q;
    idx_d = idx_q;
    data_d = data_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
    fcnt_d = fcnt_q;
    case (state_q)
      IDLE: if (pend_q | req) begin
        state_d = LOAD;
        busy_d = 1'b1;
      end
      LOAD: begin
        tag_d = ch_tag;
        bcd_d = ch_bcd;
        en_d = ch_en;
        pend_d = req;
        {valid_d, ch_d} = next_en(ch_en, 0);
        state_d = valid_d ? SEND : IDLE;
        busy_d = valid_d;
        idx_d = '0;
        data_d = "m";
      end
      SEND: if (valid_q && tx.tx_ready) begin
        if (idx_q != IW'(L - 1)) begin
          idx_d = idx_q + 1'b1;
          data_d = line_byte(ch_q, idx_q + 1'b1);
        end else if (nxt_ok) begin
          ch_d = nxt_ch;
          idx_d = '0;
          data_d = "m";
        end else begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d = 1'b1;
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= 1'b0;
      tag_q <= '0;
      bcd_q <= '0;
      en_q <= '0;
      ch_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      tag_q <= tag_d;
      bcd_q <= bcd_d;
      en_q <= en_d;
      ch_q <= ch_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fcnt_q <= fcnt_d;
    end

  assign tx.tx_data = data_q;
  assign tx.tx_valid = valid_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign frame_cnt = fcnt_q;
endmodule
